// File: rtl/sm_mac_unit.sv
// sm_mac_unit
//   Sequential sign-magnitude fixed-point multiply-accumulate for neuron dot
//   products. A run takes LEN (activation, weight) pairs, accumulates the
//   truncated products in a signed two's-complement accumulator and returns
//   one N-bit sign-magnitude result.
//
//   Handshakes: a transfer happens on a rising edge where valid and ready are
//   both high. The producer holds data stable while valid is high and ready
//   is low; ready never depends on valid in the same cycle.
//
//   Build option: define SM_MAC_SAT_EN to saturate an overflowing magnitude
//   to all ones; otherwise the magnitude wraps to its low N-1 bits.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   start       begin a new dot product (only honoured in IDLE)
//   in_valid    in_a/in_w valid
//   in_ready    unit accepts a pair this cycle
//   in_a        activation, sign-magnitude
//   in_w        weight, sign-magnitude
//   out_valid   out_result valid
//   out_ready   consumer accepts out_result
//   out_result  dot product, sign-magnitude
//   dbg_state   current FSM state, for observation only
module sm_mac_unit #(
  parameter int N    = 8,
  parameter int FRAC = 7,
  parameter int LEN  = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_w,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_result,
  output logic [1:0]   dbg_state
);

  localparam int ACC_W = N + $clog2(LEN) + 1;
  localparam int CNT_W = $clog2(LEN + 1);
  localparam int PW    = 2 * (N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_nx;

  logic [CNT_W-1:0]        cnt;
  logic [N-2:0]            p_mag;
  logic                    p_sign;
  logic                    p_valid;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] p_ext;
  logic [PW-1:0]           prod;
  logic [N-2:0]            p_next;
  logic [ACC_W-1:0]        mag;
  logic                    acc_neg;
  logic                    ovf;
  logic [N-1:0]            conv;
  logic                    xfer;

  assign in_ready  = (state == ACCUM) && (cnt < CNT_W'(LEN));
  assign out_valid = (state == DONE);
  assign dbg_state = state;
  assign xfer      = in_valid & in_ready;

  // Magnitude product, truncated after dropping the FRAC fractional bits.
  assign prod   = PW'(in_a[N-2:0]) * PW'(in_w[N-2:0]);
  assign p_next = (N-1)'(prod >> FRAC);
  assign p_ext  = signed'({{(ACC_W-N+1){1'b0}}, p_mag});

  // acc -> sign-magnitude. The accumulator is wide enough that -acc never
  // overflows, so mag is an exact absolute value.
  assign acc_neg = acc[ACC_W-1];
  assign mag     = acc_neg ? $unsigned(-acc) : $unsigned(acc);
  assign ovf     = |mag[ACC_W-1:N-1];

  always_comb begin
    conv = '0;
    if (ovf) begin
`ifdef SM_MAC_SAT_EN
      conv = {acc_neg, {(N-1){1'b1}}};
`else
      // Wrapped magnitude; a wrapped zero must not become negative zero.
      if (mag[N-2:0] != '0) conv = {acc_neg, mag[N-2:0]};
`endif
    end else if (mag[N-2:0] != '0) begin
      conv = {acc_neg, mag[N-2:0]};
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (start) state_nx = ACCUM;
      // Leave only once every pair is in and the last product has landed.
      ACCUM: if (cnt == CNT_W'(LEN) && !p_valid) state_nx = DRAIN;
      DRAIN: state_nx = DONE;
      DONE:  if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      acc        <= '0;
      p_mag      <= '0;
      p_sign     <= 1'b0;
      p_valid    <= 1'b0;
      out_result <= '0;
    end else begin
      state   <= state_nx;
      p_valid <= xfer;
      if (state == IDLE && start) begin
        acc <= '0;
        cnt <= '0;
      end
      if (xfer) begin
        p_mag  <= p_next;
        p_sign <= in_a[N-1] ^ in_w[N-1];
        cnt    <= cnt + 1'b1;
      end
      if (p_valid) acc <= p_sign ? acc - p_ext : acc + p_ext;
      if (state == DRAIN) out_result <= conv;
    end
  end

endmodule

// File: tb/tb_sm_mac_unit.sv
module tb_sm_mac_unit;

  localparam int N    = 8;
  localparam int FRAC = 7;
  localparam int LEN  = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_a;
  logic [N-1:0] in_w;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_result;
  logic [1:0]   dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [N-1:0] pa [LEN];
  logic [N-1:0] pw [LEN];

  sm_mac_unit #(.N(N), .FRAC(FRAC), .LEN(LEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_w       (in_w),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .dbg_state  (dbg_state)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: real-valued dot product on integers, then sign-magnitude.
  function automatic logic [N-1:0] model(input logic [N-1:0] a [LEN], input logic [N-1:0] w [LEN]);
    int sum;
    int p;
    int mag;
    logic s;
    sum = 0;
    for (int i = 0; i < LEN; i++) begin
      p = (int'(a[i][N-2:0]) * int'(w[i][N-2:0])) / (2 ** FRAC);
      p = p % (2 ** (N - 1));
      if (a[i][N-1] ^ w[i][N-1]) sum -= p;
      else sum += p;
    end
    s   = (sum < 0);
    mag = s ? -sum : sum;
    if (mag == 0) return '0;
    if (mag > 2 ** (N - 1) - 1) begin
`ifdef SM_MAC_SAT_EN
      return {s, {(N-1){1'b1}}};
`else
      mag = mag % (2 ** (N - 1));
      if (mag == 0) return '0;
`endif
    end
    return {s, mag[N-2:0]};
  endfunction

  // Pack four pairs as bytes, first pair in the top byte.
  task automatic load(input logic [31:0] aa, input logic [31:0] ww);
    for (int i = 0; i < LEN; i++) begin
      pa[i] = aa[8*(3-i) +: 8];
      pw[i] = ww[8*(3-i) +: 8];
    end
  endtask

  // Driver tasks; all are entered and left on a falling edge.
  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_ready", in_ready, 1);
  endtask

  // gap_mode: 0 gap-free, 1 random gaps, 2 in_valid toggling 1/0.
  task automatic feed(input int n, input int gap_mode);
    bit tog = 1'b1;
    for (int i = 0; i < n; i++) begin
      bit ok = 1'b0;
      int guard = 0;
      while (!ok && guard < 100) begin
        case (gap_mode)
          0:       in_valid = 1'b1;
          1:       in_valid = 1'($urandom_range(0, 1));
          default: begin in_valid = tog; tog = ~tog; end
        endcase
        in_a = in_valid ? pa[i] : 8'($urandom_range(0, 255));
        in_w = in_valid ? pw[i] : 8'($urandom_range(0, 255));
        #1;
        if (in_valid && in_ready) ok = 1'b1;
        @(negedge clk);
        guard++;
      end
      check("feed_accept", ok, 1);
    end
    in_valid = 1'b0;
  endtask

  task automatic run_dot(input int gap_mode, input int hold, input bit pulse,
                         input bit has_spec, input logic [N-1:0] spec_exp);
    logic [N-1:0] exp;
    int lat;
    exp = model(pa, pw);
    do_start();
    feed(LEN, gap_mode);
    check("ready_drop", in_ready, 0);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, 4);
    check("result_model", out_result, exp);
    if (has_spec) check("result_spec", out_result, spec_exp);
    for (int h = 0; h < hold; h++) begin
      start = (pulse && h == 1);
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_result", out_result, exp);
    end
    start     = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release_valid", out_valid, 0);
    check("release_ready", in_ready, 0);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_w      = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_result", out_result, 0);
    rst = 1'b0;

    // Pairs offered in IDLE without start are refused.
    in_valid = 1'b1;
    in_a     = 8'h40;
    in_w     = 8'h40;
    #1;
    check("idle_ready", in_ready, 0);
    @(negedge clk);
    check("idle_ready2", in_ready, 0);
    in_valid = 1'b0;

    load(32'h40C02000, 32'h4040407F); run_dot(0, 0, 0, 1, 8'h10);
    load(32'hC0000000, 32'h40000000); run_dot(0, 0, 0, 1, 8'hA0);
    load(32'h7F000000, 32'h7F000000); run_dot(0, 0, 0, 1, 8'h7E);
    load(32'h80000000, 32'h40000000); run_dot(0, 0, 0, 1, 8'h00);
    load(32'hC0400000, 32'h40400000); run_dot(0, 0, 0, 1, 8'h00);
`ifdef SM_MAC_SAT_EN
    load(32'h40404040, 32'h40404040); run_dot(0, 0, 0, 1, 8'h7F);
`else
    load(32'h40404040, 32'h40404040); run_dot(0, 0, 0, 1, 8'h00);
`endif
    load(32'h40C02000, 32'h4040407F); run_dot(2, 0, 0, 1, 8'h10);
    load(32'h40C02000, 32'h4040407F); run_dot(0, 5, 1, 1, 8'h10);

    // Abort after two pairs; the next run must be unaffected.
    load(32'h7F7F7F7F, 32'hFFFFFFFF);
    do_start();
    feed(2, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_in_ready", in_ready, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_out_result", out_result, 0);
    load(32'h20000000, 32'h40000000); run_dot(0, 0, 0, 1, 8'h10);

    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < LEN; i++) begin
        pa[i] = 8'($urandom_range(0, 255));
        pw[i] = 8'($urandom_range(0, 255));
      end
      run_dot(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 0, '0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
